sos_coeff_loader: RTL and testbench
===================================

Name: sos_coeff_loader

Overview:
- Writer side of the coefficient store used by the time-multiplexed SOS cascade filter.
- Accepts a stream of coefficient words over a valid/ready handshake and fills a shadow bank.
- Swaps the shadow bank into the active bank only at a filter frame boundary.
- Serves per-section coefficient reads to the filter sequencer from the active bank.

Parameters:
- No_SOS, 4, number of second-order sections (1..31).
- WIC, 2, integer bits of a filter coefficient.
- WFC, 8, fractional bits of a filter coefficient.
- WIS, 5, integer bits of a scale coefficient.
- WFS, 11, fractional bits of a scale coefficient.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous reset, active-low.
- CE  in  1  clock enable; no state changes while low.
- LD_DATA  in  max(WIC+WFC,WIS+WFS)  coefficient word; filter coefficients use the LSBs.
- LD_VALID  in  1  LD_DATA valid.
- LD_LAST  in  1  marks the final word of a load.
- LD_READY  out  1  loader accepts a word.
- SWAP_OK  in  1  filter at frame boundary (section index wrapping to 0).
- RD_SOS  in  5  section index being read.
- COEF0..COEF5  out  WIC+WFC each  b0,b1,b2,a1,a2 and the sixth section coefficient for RD_SOS.
- S_SEC  out  WIS+WFS  scale coefficient applied after section RD_SOS.
- S_IN  out  WIS+WFS  input scale coefficient.
- LOAD_ERR  out  1  sticky framing error.
- BANK_SEL  out  1  index of the active bank; toggles on every swap.

Behaviour:
- Reset (RESET=0 at a CLK edge with CE=1):
  - Both banks are zeroed, all outputs are 0, BANK_SEL=0, LOAD_ERR=0, state IDLE.
  - Reset during a load discards the partial load.
- Word order, total NW = 7*No_SOS+1 words:
  - Word 0 is S_IN.
  - For each section k, words 1+7k+j (j=0..5) are COEF j, and word 7+7k is S_SEC of section k.
- Handshake:
  - A word transfers on a CLK edge when CE=1, LD_VALID=1 and LD_READY=1.
  - LD_READY is registered: 1 in IDLE and LOAD, 0 in COMMIT and during reset.
- State machine:
  - IDLE: on a transfer, write word 0, set word count cnt=1, go to LOAD. If that first transfer carries LD_LAST=1, this is a framing error (see LOAD).
  - LOAD: each transfer writes shadow[cnt] and increments cnt.
    - LD_LAST=1 with cnt=NW-1: go to COMMIT.
    - LD_LAST=1 with cnt≠NW-1, or LD_LAST=0 with cnt=NW-1: set LOAD_ERR, discard the shadow bank, go to IDLE.
  - COMMIT: wait for SWAP_OK=1. At that edge, BANK_SEL toggles and the shadow becomes active. Go to IDLE.
- SWAP_OK in IDLE or LOAD is ignored. The active bank never changes except at a COMMIT swap or at reset.
- LOAD_ERR clears only on reset. A new load after an error is accepted normally.
- Read port:
  - COEF0..5 and S_SEC are registered, latency 1 cycle from RD_SOS.
  - On a swap edge, a read issued in that cycle returns the old bank.
  - RD_SOS ≥ No_SOS returns zeros.
  - S_IN is registered from the active bank and updates on the cycle after a swap.
- Truncation: filter coefficients take LD_DATA[WIC+WFC-1:0]; upper bits are ignored and no saturation is applied.

Optional Feature:
- Macro: SOS_COEFF_CHECKSUM_EN.
- Defined:
  - NW+1 words are expected, and LD_LAST must be on word NW.
  - Word NW is the two's-complement sum, mod 2^width(LD_DATA), of words 0..NW-1.
  - A mismatch sets LOAD_ERR and discards the shadow bank instead of entering COMMIT.
- Undefined: no checksum word; the behaviour is as specified above.

Decomposition:
- Package sos_coeff_pkg holds:
  - the state enum (IDLE, LOAD, COMMIT);
  - the NW and data-width constants;
  - the index-layout functions (section/coefficient to word index).
- Sub-module sos_coeff_bank: one register file of NW words with a write port and a section read port, instantiated twice for the ping-pong banks.

Test Plan:
- Reset check:
  - Stimulus: hold RESET=0 for 3 cycles, then release.
  - Required: all outputs 0; LD_READY=0 during reset and 1 on the first cycle after release; BANK_SEL=0.
- Full load with immediate swap:
  - Stimulus: No_SOS=4, send 29 words with word n=n+1, hold SWAP_OK=1.
  - Required: BANK_SEL=1 after the last word plus 1 cycle. Then RD_SOS=2 gives COEF0=16, COEF5=21, S_SEC=22 one cycle later, and S_IN=1.
- Swap deferral:
  - Stimulus: after the last word, hold SWAP_OK=0 for 10 cycles, then pulse it for 1 cycle.
  - Required: LD_READY=0 and old-bank values on all reads throughout the wait; the swap occurs on the pulse edge.
- Early LD_LAST:
  - Stimulus: assert LD_LAST on word 10.
  - Required: LOAD_ERR=1, BANK_SEL unchanged, active values unchanged, LD_READY=1. A following correct load still swaps.
- Gaps and reset mid-load:
  - Stimulus: random LD_VALID gaps and CE low for 5 cycles mid-load, then a completed load.
  - Required: identical results to the gap-free load.
  - Stimulus: RESET=0 at word 12.
  - Required: all outputs 0 and the next load starts at word 0.
- Out-of-range read:
  - Stimulus: RD_SOS=4 and RD_SOS=31 after a valid load.
  - Required: COEF0..5=0 and S_SEC=0.

Source files
------------

// File: rtl/sos_coeff_pkg.sv
// Shared types, constants and coefficient word-layout helpers for the SOS coefficient loader.
package sos_coeff_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned WORDS_PER_SOS = 7;
  localparam int unsigned NCOEF         = 6;
  localparam int unsigned RD_W          = 5;
  localparam int unsigned CNT_W         = 8;

  function automatic int unsigned num_words(input int unsigned n_sos);
    return WORDS_PER_SOS * n_sos + 1;
  endfunction

  function automatic int unsigned data_width(input int unsigned wc, input int unsigned ws);
    return (wc > ws) ? wc : ws;
  endfunction

  function automatic int unsigned coef_idx(input int unsigned sec, input int unsigned j);
    return 1 + WORDS_PER_SOS * sec + j;
  endfunction

  function automatic int unsigned scale_idx(input int unsigned sec);
    return WORDS_PER_SOS + WORDS_PER_SOS * sec;
  endfunction

endpackage

// File: rtl/sos_coeff_bank.sv
// One coefficient register file: word write port, clear, and a combinational per-section read port.
module sos_coeff_bank
  import sos_coeff_pkg::*;
#(
  parameter int unsigned No_SOS = 4,
  parameter int unsigned NW     = 29,
  parameter int unsigned WD     = 16,
  parameter int unsigned WC     = 10,
  parameter int unsigned WS     = 16
) (
  input  logic                        CLK,
  input  logic                        CE,
  input  logic                        CLR,
  input  logic                        WE,
  input  logic [CNT_W-1:0]            WADDR,
  input  logic [WD-1:0]               WDATA,
  input  logic [RD_W-1:0]             RD_SOS,
  output logic [NCOEF-1:0][WC-1:0]    COEF,
  output logic [WS-1:0]               S_SEC,
  output logic [WS-1:0]               S_IN
);

  logic [WD-1:0] mem [NW];

  always_ff @(posedge CLK) begin
    if (CE) begin
      for (int unsigned i = 0; i < NW; i++) begin
        if (CLR)
          mem[i] <= '0;
        else if (WE && WADDR == CNT_W'(i))
          mem[i] <= WDATA;
      end
    end
  end

  // Sections at or beyond No_SOS match no entry and read as zero.
  always_comb begin
    COEF  = '0;
    S_SEC = '0;
    for (int unsigned s = 0; s < No_SOS; s++) begin
      if (RD_SOS == RD_W'(s)) begin
        for (int unsigned j = 0; j < NCOEF; j++)
          COEF[j] = mem[coef_idx(s, j)][WC-1:0];
        S_SEC = mem[scale_idx(s)][WS-1:0];
      end
    end
  end

  assign S_IN = mem[0][WS-1:0];

endmodule

// File: rtl/sos_coeff_loader.sv
// Coefficient loader with ping-pong banks swapped at frame boundaries.
// Optional trailing checksum word enabled by SOS_COEFF_CHECKSUM_EN.
module sos_coeff_loader
  import sos_coeff_pkg::*;
#(
  parameter int unsigned No_SOS = 4,
  parameter int unsigned WIC    = 2,
  parameter int unsigned WFC    = 8,
  parameter int unsigned WIS    = 5,
  parameter int unsigned WFS    = 11
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic                                        CE,
  input  logic [data_width(WIC+WFC, WIS+WFS)-1:0]     LD_DATA,
  input  logic                                        LD_VALID,
  input  logic                                        LD_LAST,
  output logic                                        LD_READY,
  input  logic                                        SWAP_OK,
  input  logic [RD_W-1:0]                             RD_SOS,
  output logic [WIC+WFC-1:0]                          COEF0,
  output logic [WIC+WFC-1:0]                          COEF1,
  output logic [WIC+WFC-1:0]                          COEF2,
  output logic [WIC+WFC-1:0]                          COEF3,
  output logic [WIC+WFC-1:0]                          COEF4,
  output logic [WIC+WFC-1:0]                          COEF5,
  output logic [WIS+WFS-1:0]                          S_SEC,
  output logic [WIS+WFS-1:0]                          S_IN,
  output logic                                        LOAD_ERR,
  output logic                                        BANK_SEL
);

  localparam int unsigned WC = WIC + WFC;
  localparam int unsigned WS = WIS + WFS;
  localparam int unsigned WD = data_width(WC, WS);
  localparam int unsigned NW = num_words(No_SOS);
`ifdef SOS_COEFF_CHECKSUM_EN
  localparam int unsigned NT = NW + 1;
`else
  localparam int unsigned NT = NW;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NT - 1);
  localparam logic [CNT_W-1:0] NW_IDX   = CNT_W'(NW);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [CNT_W-1:0]         cur;
  logic                     xfer, wr_en, end_ok, end_bad, sum_ok;
  logic                     we0, we1, clr0, clr1;
  logic [NCOEF-1:0][WC-1:0] coef0_b, coef1_b, coef_q;
  logic [WS-1:0]            ssec0_b, ssec1_b, sin0_b, sin1_b;

`ifdef SOS_COEFF_CHECKSUM_EN
  logic [WD-1:0] csum;

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESET)
        csum <= '0;
      else if (xfer)
        csum <= ((state == IDLE) ? '0 : csum) + LD_DATA;
    end
  end

  assign sum_ok = (csum == LD_DATA);
`else
  assign sum_ok = 1'b1;
`endif

  always_comb begin
    xfer    = CE & LD_VALID & LD_READY;
    cur     = (state == LOAD) ? cnt : '0;
    wr_en   = xfer && (cur < NW_IDX);
    end_ok  = 1'b0;
    end_bad = 1'b0;
    if (xfer) begin
      if (LD_LAST && cur == LAST_IDX && sum_ok)
        end_ok = 1'b1;
      else if (LD_LAST || cur == LAST_IDX)
        end_bad = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESET) begin
        state    <= IDLE;
        cnt      <= '0;
        LD_READY <= 1'b0;
        BANK_SEL <= 1'b0;
        LOAD_ERR <= 1'b0;
      end else begin
        LD_READY <= 1'b1;
        case (state)
          IDLE, LOAD: begin
            if (end_ok) begin
              state    <= COMMIT;
              LD_READY <= 1'b0;
            end else if (end_bad) begin
              state    <= IDLE;
              LOAD_ERR <= 1'b1;
            end else if (xfer) begin
              state <= LOAD;
              cnt   <= cur + 1'b1;
            end
          end
          COMMIT: begin
            if (SWAP_OK) begin
              BANK_SEL <= ~BANK_SEL;
              state    <= IDLE;
            end else begin
              LD_READY <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Writes and error discards target the shadow bank, i.e. the one not selected by BANK_SEL.
  assign we0  = wr_en & BANK_SEL;
  assign we1  = wr_en & ~BANK_SEL;
  assign clr0 = ~RESET | (end_bad & BANK_SEL);
  assign clr1 = ~RESET | (end_bad & ~BANK_SEL);

  sos_coeff_bank #(.No_SOS(No_SOS), .NW(NW), .WD(WD), .WC(WC), .WS(WS)) u_bank0 (
    .CLK(CLK), .CE(CE), .CLR(clr0), .WE(we0), .WADDR(cur), .WDATA(LD_DATA),
    .RD_SOS(RD_SOS), .COEF(coef0_b), .S_SEC(ssec0_b), .S_IN(sin0_b)
  );

  sos_coeff_bank #(.No_SOS(No_SOS), .NW(NW), .WD(WD), .WC(WC), .WS(WS)) u_bank1 (
    .CLK(CLK), .CE(CE), .CLR(clr1), .WE(we1), .WADDR(cur), .WDATA(LD_DATA),
    .RD_SOS(RD_SOS), .COEF(coef1_b), .S_SEC(ssec1_b), .S_IN(sin1_b)
  );

  // Selection uses the pre-edge BANK_SEL, so a read on the swap edge still sees the old bank.
  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESET) begin
        coef_q <= '0;
        S_SEC  <= '0;
        S_IN   <= '0;
      end else if (BANK_SEL) begin
        coef_q <= coef1_b;
        S_SEC  <= ssec1_b;
        S_IN   <= sin1_b;
      end else begin
        coef_q <= coef0_b;
        S_SEC  <= ssec0_b;
        S_IN   <= sin0_b;
      end
    end
  end

  assign COEF0 = coef_q[0];
  assign COEF1 = coef_q[1];
  assign COEF2 = coef_q[2];
  assign COEF3 = coef_q[3];
  assign COEF4 = coef_q[4];
  assign COEF5 = coef_q[5];

endmodule

// File: tb/tb_sos_coeff_loader.sv
// Scoreboard testbench for sos_coeff_loader: directed loads, swap timing, framing errors, reads.
`timescale 1ns/1ps
module tb_sos_coeff_loader;

  localparam int NSOS = 4;
  localparam int NW   = 7 * NSOS + 1;
`ifdef SOS_COEFF_CHECKSUM_EN
  localparam int NT = NW + 1;
`else
  localparam int NT = NW;
`endif

  logic        CLK = 1'b0, RESET = 1'b0, CE = 1'b0;
  logic        LD_VALID = 1'b0, LD_LAST = 1'b0, SWAP_OK = 1'b0;
  logic [15:0] LD_DATA = '0;
  logic [4:0]  RD_SOS = '0;
  logic        LD_READY, LOAD_ERR, BANK_SEL;
  logic [9:0]  COEF0, COEF1, COEF2, COEF3, COEF4, COEF5;
  logic [15:0] S_SEC, S_IN;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0][9:0] c;
    logic [15:0]     s;
  } rd_t;

  logic [15:0] act [NW];
  rd_t         expq [$];
  logic        rd_req = 1'b0;
  logic        rd_cap = 1'b0;

  always #5 CLK = ~CLK;

  sos_coeff_loader #(.No_SOS(NSOS), .WIC(2), .WFC(8), .WIS(5), .WFS(11)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE),
    .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_LAST(LD_LAST), .LD_READY(LD_READY),
    .SWAP_OK(SWAP_OK), .RD_SOS(RD_SOS),
    .COEF0(COEF0), .COEF1(COEF1), .COEF2(COEF2), .COEF3(COEF3), .COEF4(COEF4), .COEF5(COEF5),
    .S_SEC(S_SEC), .S_IN(S_IN), .LOAD_ERR(LOAD_ERR), .BANK_SEL(BANK_SEL)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic rd_t model(input int s);
    rd_t r = '0;
    if (s < NSOS) begin
      for (int j = 0; j < 6; j++) r.c[j] = act[1 + 7*s + j][9:0];
      r.s = act[7 + 7*s];
    end
    return r;
  endfunction

  task automatic set_model(input int off);
    for (int n = 0; n < NW; n++) act[n] = 16'(off + n);
  endtask

  // Read monitor: compares registered outputs one cycle after each issued read.
  always @(posedge CLK) rd_cap <= rd_req && CE;

  always @(negedge CLK) begin
    rd_t got, e;
    if (rd_cap) begin
      got.c = {COEF5, COEF4, COEF3, COEF2, COEF1, COEF0};
      got.s = S_SEC;
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rd_sb: read output %h with no expectation queued", got);
      end else begin
        e = expq.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL rd_sb: got %h expected %h", got, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic rd(input int s);
    RD_SOS = 5'(s);
    expq.push_back(model(s));
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input bit last);
    bit ok = 1'b0;
    int n  = 0;
    LD_DATA  = d;
    LD_LAST  = last;
    LD_VALID = 1'b1;
    while (!ok && n < 200) begin
      @(negedge CLK);
      ok = CE && LD_READY;
      @(posedge CLK);
      #2;
      n++;
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=%0d expected 1 within 200 cycles", LD_READY);
    end
  endtask

  // Word n carries off+n; last_at<0 means LD_LAST on the final word; stop_at aborts before that word.
  task automatic load_frame(input int off, input int last_at, input bit gaps,
                            input int ce_at, input int stop_at);
    logic [15:0] w;
    logic [15:0] sum = '0;
    bit          last;
    for (int n = 0; n < NT; n++) begin
      if (n == stop_at) return;
      w = (n == NW) ? sum : 16'(off + n);
      if (n < NW) sum = sum + w;
      last = (last_at >= 0) ? (n == last_at) : (n == NT - 1);
      if (gaps) tick($urandom_range(0, 2));
      if (n == ce_at) begin
        LD_DATA  = w;
        LD_VALID = 1'b1;
        CE       = 1'b0;
        tick(5);
        CE       = 1'b1;
      end
      send(w, last);
      if (last) return;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int n = 0; n < NW; n++) act[n] = '0;

    // Reset for three cycles
    RESET = 1'b0;
    CE    = 1'b1;
    tick(3);
    chk("rst_ready", LD_READY, 0);
    chk("rst_bank", BANK_SEL, 0);
    chk("rst_err", LOAD_ERR, 0);
    chk("rst_sin", S_IN, 0);
    chk("rst_coef", {COEF0, COEF5}, 0);
    RESET = 1'b1;
    tick();
    chk("rel_ready", LD_READY, 1);
    rd(0);

    // Full load, immediate swap
    SWAP_OK = 1'b1;
    load_frame(1, -1, 0, -1, NT);
    chk("commit_ready", LD_READY, 0);
    tick();
    chk("swap_bank", BANK_SEL, 1);
    chk("sin_swap_edge", S_IN, 0);
    set_model(1);
    tick();
    chk("sin_after", S_IN, 1);
    rd(2);
    chk("s2_coef0", COEF0, 16);
    chk("s2_coef5", COEF5, 21);
    chk("s2_ssec", S_SEC, 22);
    rd(0);
    rd(3);

    // Swap deferral
    SWAP_OK = 1'b0;
    load_frame(101, -1, 0, -1, NT);
    for (int i = 0; i < 10; i++) begin
      chk("defer_ready", LD_READY, 0);
      chk("defer_bank", BANK_SEL, 1);
      rd(i % 4);
    end
    SWAP_OK = 1'b1;
    rd(1);
    SWAP_OK = 1'b0;
    chk("defer_swap", BANK_SEL, 0);
    chk("defer_sin_old", S_IN, 1);
    set_model(101);
    tick();
    chk("defer_sin_new", S_IN, 101);
    rd(2);
    chk("defer_coef0", COEF0, 116);

    // Early LD_LAST on word 10
    SWAP_OK = 1'b1;
    load_frame(201, 10, 0, -1, NT);
    chk("early_err", LOAD_ERR, 1);
    chk("early_ready", LD_READY, 1);
    tick(2);
    chk("early_bank", BANK_SEL, 0);
    chk("early_sin", S_IN, 101);
    for (int s = 0; s < NSOS; s++) rd(s);
    load_frame(301, -1, 0, -1, NT);
    tick();
    chk("recover_bank", BANK_SEL, 1);
    set_model(301);
    tick();
    rd(1);
    chk("recover_err_sticky", LOAD_ERR, 1);

    // Gaps plus CE low mid-load
    load_frame(1, -1, 1, 14, NT);
    tick();
    chk("gap_bank", BANK_SEL, 0);
    set_model(1);
    tick();
    rd(2);
    chk("gap_coef0", COEF0, 16);
    chk("gap_ssec", S_SEC, 22);
    chk("gap_sin", S_IN, 1);

    // Reset at word 12
    load_frame(50, -1, 0, -1, 12);
    RESET = 1'b0;
    tick();
    chk("mid_rst_ready", LD_READY, 0);
    chk("mid_rst_bank", BANK_SEL, 0);
    chk("mid_rst_err", LOAD_ERR, 0);
    chk("mid_rst_sin", S_IN, 0);
    chk("mid_rst_coef", {COEF0, COEF5, S_SEC}, 0);
    for (int n = 0; n < NW; n++) act[n] = '0;
    RESET = 1'b1;
    tick();
    chk("mid_rel_ready", LD_READY, 1);
    rd(2);
    load_frame(7, -1, 0, -1, NT);
    tick();
    chk("post_rst_bank", BANK_SEL, 1);
    set_model(7);
    tick();
    rd(2);
    chk("post_rst_coef0", COEF0, 22);
    chk("post_rst_sin", S_IN, 7);

    // Out-of-range section reads
    rd(4);
    chk("oor4_coef", {COEF0, COEF5, S_SEC}, 0);
    rd(31);
    chk("oor31_coef", {COEF0, COEF3, S_SEC}, 0);
    rd(3);

    SWAP_OK = 1'b0;
    tick(3);
    chk("sb_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
